// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding and default event channel indices for the performance monitor
package perf_pkg;
  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;
  localparam int EVT_INST  = 0;
  localparam int EVT_ICREQ = 1;
  localparam int EVT_ICHIT = 2;
  localparam int EVT_DCREQ = 3;
  localparam int EVT_DCHIT = 4;
endpackage

// File: rtl/perf_ctr.sv
// perf_ctr: single event counter with wrap or saturate overflow and a sticky overflow flag
module perf_ctr #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  logic top;
  assign top = &cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      cnt <= (top && SATURATE) ? cnt : cnt + 1'b1;
      ovf <= ovf | top;
    end
  end
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: multi-channel event counters with freeze control and a registered readout port
module perf_monitor
  import perf_pkg::*;
#(
  parameter int NUM_EVT  = 5,
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0,
  parameter int SEL_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               halt,
  input  logic               clr,
  input  logic               rd_req,
  input  logic [SEL_W-1:0]   rd_sel,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               frozen,
  output logic [NUM_EVT-1:0] ovf
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt [NUM_EVT];
  logic [CNT_W-1:0] sel_data;
  always_ff @(posedge clk) begin
    state <= rst ? RUN : state_nx;
  end
  always_comb begin
    state_nx = clr ? RUN : (halt ? FROZEN : state);
  end
  always_comb begin
    frozen = (state == FROZEN);
  end
  for (genvar g = 0; g < NUM_EVT; g++) begin : g_ctr
    perf_ctr #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (en && evt[g] && state == RUN),
      .clr (clr),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end
  // out-of-range selects fall through to zero
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_EVT; i++)
      if (rd_sel == SEL_W'(i)) sel_data = cnt[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? sel_data : rd_data;
    end
  end
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: random and directed stimulus against a counting model, three parameterisations in parallel
module tb_perf_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, halt, clr, rd_req;
  logic [4:0] evt;
  logic [2:0] rd_sel;
  logic [31:0] d_a;
  logic [3:0] d_b, d_c;
  logic v_a, v_b, v_c, f_a, f_b, f_c;
  logic [4:0] o_a, o_b, o_c;
  perf_monitor #(.NUM_EVT(5), .CNT_W(32), .SATURATE(0), .SEL_W(3)) u_a (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_valid(v_a), .rd_data(d_a), .frozen(f_a), .ovf(o_a));
  perf_monitor #(.NUM_EVT(5), .CNT_W(4), .SATURATE(0), .SEL_W(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_valid(v_b), .rd_data(d_b), .frozen(f_b), .ovf(o_b));
  perf_monitor #(.NUM_EVT(5), .CNT_W(4), .SATURATE(1), .SEL_W(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .evt(evt), .halt(halt), .clr(clr), .rd_req(rd_req),
    .rd_sel(rd_sel), .rd_valid(v_c), .rd_data(d_c), .frozen(f_c), .ovf(o_c));
  int n_chk = 0, n_err = 0;
  longint mc [3][5];
  bit mo [3][5];
  longint md [3];
  bit mf, mv;
  int wid [3] = '{32, 4, 4};
  bit sat [3] = '{1'b0, 1'b0, 1'b1};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] ovf_of(input int k);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = mo[k][i];
    return r;
  endfunction
  task automatic model_edge;
    longint mx;
    if (rst) begin
      mf = 0; mv = 0;
      for (int k = 0; k < 3; k++) begin
        md[k] = 0;
        for (int i = 0; i < 5; i++) begin mc[k][i] = 0; mo[k][i] = 0; end
      end
    end else begin
      mv = rd_req;
      for (int k = 0; k < 3; k++)
        if (rd_req) md[k] = (rd_sel < 5) ? mc[k][rd_sel] : 0;
      if (clr) begin
        mf = 0;
        for (int k = 0; k < 3; k++)
          for (int i = 0; i < 5; i++) begin mc[k][i] = 0; mo[k][i] = 0; end
      end else begin
        if (!mf && en)
          for (int k = 0; k < 3; k++) begin
            mx = (longint'(1) << wid[k]) - 1;
            for (int i = 0; i < 5; i++)
              if (evt[i]) begin
                if (mc[k][i] == mx) begin
                  mo[k][i] = 1;
                  mc[k][i] = sat[k] ? mx : 0;
                end else mc[k][i]++;
              end
          end
        if (halt) mf = 1;
      end
    end
  endtask
  task automatic step;
    @(posedge clk);
    model_edge();
    #1;
    check("frozen_a", f_a, mf);
    check("frozen_b", f_b, mf);
    check("frozen_c", f_c, mf);
    check("rd_valid_a", v_a, mv);
    check("rd_valid_b", v_b, mv);
    check("rd_valid_c", v_c, mv);
    check("rd_data_a", d_a, md[0][31:0]);
    check("rd_data_b", d_b, md[1][31:0]);
    check("rd_data_c", d_c, md[2][31:0]);
    check("ovf_a", o_a, ovf_of(0));
    check("ovf_b", o_b, ovf_of(1));
    check("ovf_c", o_c, ovf_of(2));
  endtask
  task automatic drive(input logic r, input logic e, input logic [4:0] ev, input logic h,
                       input logic c, input logic rq, input logic [2:0] sel);
    rst = r; en = e; evt = ev; halt = h; clr = c; rd_req = rq; rd_sel = sel;
    step();
  endtask
  initial begin
    rst = 1; en = 0; evt = 0; halt = 0; clr = 0; rd_req = 0; rd_sel = 0;
    drive(1, 1, 5'h1f, 1, 1, 1, 0);
    check("reset_frozen", f_a, 0);
    check("reset_valid", v_a, 0);
    check("reset_data", d_a, 0);
    check("reset_ovf", o_a, 0);
    // counting scenario
    repeat (10) drive(0, 1, 5'b00001, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 5'b10101, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0); check("count_ch0", d_a, 13);
    drive(0, 1, 0, 0, 0, 1, 2); check("count_ch2", d_a, 3);
    drive(0, 1, 0, 0, 0, 1, 4); check("count_ch4", d_a, 3);
    // halt scenario
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 5'b00010, 0, 0, 0, 0);
    drive(0, 1, 5'b00010, 1, 0, 0, 0);
    repeat (5) drive(0, 1, 5'b00010, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 1, 1);
    check("halt_frozen", f_a, 1);
    check("halt_ch1", d_a, 4);
    // wrap and saturate on the 4-bit instances
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (17) drive(0, 1, 5'b00001, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    check("wrap_data", d_b, 1);
    check("wrap_ovf", o_b[0], 1);
    check("sat_data", d_c, 15);
    check("sat_ovf", o_c[0], 1);
    // clear priority with a readout in the clear cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    repeat (7) drive(0, 1, 5'b01000, 0, 0, 0, 0);
    drive(0, 1, 5'b01000, 1, 1, 1, 3);
    check("clr_read_pre", d_a, 7);
    check("clr_frozen", f_a, 0);
    drive(0, 1, 0, 0, 0, 1, 3);
    check("clr_cnt3", d_a, 0);
    // readout edges
    drive(0, 1, 5'b00011, 0, 0, 1, 7);
    check("oob_data", d_a, 0);
    check("oob_valid", v_a, 1);
    drive(0, 1, 0, 0, 0, 1, 0); check("b2b_v0", v_a, 1);
    drive(0, 1, 0, 0, 0, 1, 1); check("b2b_v1", v_a, 1);
    drive(0, 1, 0, 0, 0, 0, 0); check("idle_valid", v_a, 0);
    drive(0, 1, 0, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 0, 1, 0); check("rst_kills_valid", v_a, 0);
    // random traffic
    for (int n = 0; n < 3000; n++)
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 5'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
            1'($urandom), 3'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_EVT, default 5, number of independent event channels (1..16).
REQ-002 Parameter CNT_W, default 32, counter width in bits (4..32).
REQ-003 Parameter SATURATE, default 0; 0 = counters wrap at overflow, 1 = counters hold at all-ones.
REQ-004 Parameter SEL_W, default 3, rd_sel width; SHALL satisfy 2**SEL_W >= NUM_EVT.
REQ-005 There is one clock, clk; reset is rst, synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 en  in  1  global count enable; 0 = no counter advances.
REQ-009 evt  in  NUM_EVT  per-channel event strobe; each set bit means one event in this cycle.
REQ-010 halt  in  1  processor-halt strobe; freezes counting.
REQ-011 clr  in  1  clears all counters and overflow flags, and unfreezes.
REQ-012 rd_req  in  1  readout request.
REQ-013 rd_sel  in  SEL_W  channel index for the readout.
REQ-014 rd_valid  out  1  readout data valid, one-cycle pulse.
REQ-015 rd_data  out  CNT_W  counter value returned by the readout.
REQ-016 frozen  out  1  high while in state FROZEN.
REQ-017 ovf  out  NUM_EVT  sticky per-channel overflow flags.

Function
REQ-018 The controller SHALL have two states, RUN and FROZEN; frozen = (state == FROZEN).
REQ-019 In RUN, each channel i with en && evt[i] SHALL increment cnt[i] by exactly 1 at the clock edge.
REQ-020 Any combination of channels SHALL count in the same cycle, with no arbitration.
REQ-021 In FROZEN, no counter SHALL change, regardless of en or evt.
REQ-022 halt in RUN SHALL move the state to FROZEN at the next edge; events in that same cycle SHALL still be counted.
REQ-023 halt while in FROZEN SHALL have no effect.
REQ-024 clr SHALL zero every counter and every ovf bit and SHALL set the state to RUN at the next edge, whatever the current state.
REQ-025 clr SHALL take priority over evt and halt in the same cycle: counters become 0, state becomes RUN, and nothing is counted.
REQ-026 Overflow with SATURATE=0: an increment from 2**CNT_W-1 SHALL yield 0 and set ovf[i].
REQ-027 Overflow with SATURATE=1: an increment at 2**CNT_W-1 SHALL hold the value and set ovf[i].
REQ-028 ovf[i] SHALL stay set until clr or rst.
REQ-029 A readout sampled at edge t SHALL drive rd_valid=1 and rd_data=cnt[rd_sel] during cycle t+1, using the counter value before any update at edge t.
REQ-030 Readouts SHALL be accepted in both states and back-to-back every cycle; rd_valid SHALL be 0 in any cycle after an edge where rd_req=0.
REQ-031 rd_sel >= NUM_EVT SHALL return rd_data=0 with rd_valid=1.
REQ-032 A readout in the same cycle as clr SHALL return the pre-clear value.

Reset
REQ-033 At reset the state SHALL be RUN, all cnt[i]=0, ovf=0, rd_valid=0, rd_data=0, frozen=0.
REQ-034 rst SHALL override clr, halt, evt and rd_req.
REQ-035 rst asserted mid-readout SHALL suppress the pending rd_valid.

Structure
REQ-036 A shared package perf_pkg SHALL hold the state enum (RUN, FROZEN) and the default channel indices: EVT_INST=0, EVT_ICREQ=1, EVT_ICHIT=2, EVT_DCREQ=3, EVT_DCHIT=4.
REQ-037 The per-channel counter SHALL be a sub-module perf_ctr (inputs inc, clr; parameters CNT_W, SATURATE; outputs cnt, ovf), instantiated NUM_EVT times in a generate loop.
REQ-038 The readout mux and the state register SHALL reside in perf_monitor.

Verification
REQ-039 Counting: reset; en=1; evt=5'b00001 for 10 cycles, then evt=5'b10101 for 3 cycles; read channels 0, 2, 4 -> 13, 3, 3.
REQ-040 Halt: 4 cycles of evt[1] with halt in the 4th cycle, then 5 more cycles of evt[1] -> frozen=1 and cnt[1]=4.
REQ-041 Wrap: CNT_W=4, SATURATE=0; 17 events on channel 0 -> rd_data=1 and ovf[0]=1.
REQ-042 Saturate: CNT_W=4, SATURATE=1; 20 events on channel 0 -> rd_data=15 and ovf[0]=1.
REQ-043 Clear priority: cnt[3]=7; clr, halt and evt[3] in the same cycle -> next cycle cnt[3]=0 and frozen=0; a readout in the clr cycle returns 7.
REQ-044 Readout edges: rd_sel=7 with NUM_EVT=5 -> rd_data=0, rd_valid=1; back-to-back reads of channels 0 then 1 -> two consecutive valid cycles.
